instr_issue_ctrl: RTL and testbench

INSTR_ISSUE_CTRL -- requirements
Module: instr_issue_ctrl

---
 rtl/instr_issue_ctrl.sv | 134 +++++++++++++
 tb/tb_instr_issue_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_ctrl.sv
// Instruction issue controller: a FIFO buffer in front of the DataPath that issues one word per cycle
// and inserts NOP bubbles while the head instruction reads a recently issued destination register.
module instr_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int HAZ_WIN = 1
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic [31:0] instruction,
  output logic        issue_valid,
  output logic [15:0] bubble_cnt,
  output logic        busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_BUBBLE = 2'd2;

  logic [31:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [4:0]       r_hist [HAZ_WIN];
  logic [1:0]       r_state;
  logic [31:0]      r_instruction;
  logic             r_issue_valid;
  logic [15:0]      r_bubble_cnt;

  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_stall;
  logic        w_hazard;
  logic [31:0] w_head;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_head_dst;
  logic [1:0]  w_state_nxt;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_head  = r_mem[r_rd_ptr];
  assign w_rs    = w_head[25:21];
  assign w_rt    = w_head[20:16];
  // Only R-type words write a register; rd=0 doubles as the "no destination" marker in the history.
  assign w_head_dst = (w_head[31:26] == 6'd0) ? w_head[15:11] : 5'd0;

  // NOTE: every always_comb output gets a default before any condition so no latch can be inferred.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < HAZ_WIN; i++) begin
      if (r_hist[i] != 5'd0 && (r_hist[i] == w_rs || r_hist[i] == w_rt)) begin
        w_hazard = 1'b1;
      end
    end
  end

  assign w_stall = !w_empty && w_hazard;
  assign w_pop   = !w_empty && !w_hazard;
  assign w_push  = in_valid && !w_full;

  always_comb begin
    w_state_nxt = ST_RUN;
    if (w_empty) begin
      w_state_nxt = ST_IDLE;
    end else if (w_stall) begin
      w_state_nxt = ST_BUBBLE;
    end
  end

  // NOTE: the storage array has no reset; occupancy and pointers alone decide which entries are live.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_instr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_state       <= ST_IDLE;
      r_instruction <= 32'h0000_0000;
      r_issue_valid <= 1'b0;
      r_bubble_cnt  <= 16'd0;
      for (int i = 0; i < HAZ_WIN; i++) begin
        r_hist[i] <= 5'd0;
      end
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end

      r_state       <= w_state_nxt;
      r_instruction <= w_pop ? w_head : 32'h0000_0000;
      r_issue_valid <= w_pop;

      // A NOP shifts in "none", which is how a bubble ages the hazard out of the window.
      for (int i = HAZ_WIN - 1; i > 0; i--) begin
        r_hist[i] <= r_hist[i-1];
      end
      r_hist[0] <= w_pop ? w_head_dst : 5'd0;

      if (w_stall && r_bubble_cnt != 16'hFFFF) begin
        r_bubble_cnt <= r_bubble_cnt + 16'd1;
      end
    end
  end

  assign in_ready    = !w_full;
  assign instruction = r_instruction;
  assign issue_valid = r_issue_valid;
  assign bubble_cnt  = r_bubble_cnt;
  assign busy        = !w_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Bench for instr_issue_ctrl: two instances (HAZ_WIN=1 and 2) share stimulus and are compared every cycle
// against a shift-array buffer model driven by the hazard rules.
module tb_instr_issue_ctrl;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        in_valid;
  logic [31:0] in_instr;

  logic        o_ready   [2];
  logic [31:0] o_instr   [2];
  logic        o_iv      [2];
  logic [15:0] o_bubble  [2];
  logic        o_busy    [2];

  instr_issue_ctrl #(.DEPTH(DEPTH), .HAZ_WIN(1)) u_dut1 (
    .CLK(CLK), .RSTn(RSTn), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(o_ready[0]), .instruction(o_instr[0]), .issue_valid(o_iv[0]),
    .bubble_cnt(o_bubble[0]), .busy(o_busy[0])
  );

  instr_issue_ctrl #(.DEPTH(DEPTH), .HAZ_WIN(2)) u_dut2 (
    .CLK(CLK), .RSTn(RSTn), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(o_ready[1]), .instruction(o_instr[1]), .issue_valid(o_iv[1]),
    .bubble_cnt(o_bubble[1]), .busy(o_busy[1])
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: element 0 of m_buf is the head; popping shifts the array down.
  int          haz_win [2] = '{1, 2};
  logic [31:0] m_buf   [2][DEPTH];
  int          m_cnt   [2];
  logic [4:0]  m_hist  [2][3];
  logic [31:0] m_instr [2];
  logic        m_iv    [2];
  int          m_bub   [2];
  logic        m_active[2];

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
  endfunction

  task automatic model_step(input int k);
    logic        nonempty;
    logic        haz;
    logic        can_push;
    logic [31:0] head;
    logic [4:0]  dst;
    if (!RSTn) begin
      m_cnt[k]    = 0;
      m_instr[k]  = 32'h0;
      m_iv[k]     = 1'b0;
      m_bub[k]    = 0;
      m_active[k] = 1'b0;
      for (int i = 0; i < 3; i++) m_hist[k][i] = 5'd0;
    end else begin
      nonempty = (m_cnt[k] > 0);
      can_push = (m_cnt[k] < DEPTH);
      head     = m_buf[k][0];
      haz      = 1'b0;
      dst      = 5'd0;
      if (nonempty) begin
        for (int i = 0; i < haz_win[k]; i++) begin
          if (m_hist[k][i] != 5'd0 &&
              (m_hist[k][i] == head[25:21] || m_hist[k][i] == head[20:16])) haz = 1'b1;
        end
      end
      if (nonempty && !haz) begin
        m_instr[k] = head;
        m_iv[k]    = 1'b1;
        dst        = (head[31:26] == 6'd0) ? head[15:11] : 5'd0;
        for (int i = 0; i < DEPTH - 1; i++) m_buf[k][i] = m_buf[k][i+1];
        m_cnt[k]--;
      end else begin
        m_instr[k] = 32'h0;
        m_iv[k]    = 1'b0;
      end
      if (in_valid && can_push) begin
        m_buf[k][m_cnt[k]] = in_instr;
        m_cnt[k]++;
      end
      m_hist[k][2] = m_hist[k][1];
      m_hist[k][1] = m_hist[k][0];
      m_hist[k][0] = dst;
      if (nonempty && haz && m_bub[k] < 65535) m_bub[k]++;
      m_active[k] = nonempty;
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("instr[%0d]", k),  o_instr[k],        m_instr[k]);
      check($sformatf("valid[%0d]", k),  32'(o_iv[k]),      32'(m_iv[k]));
      check($sformatf("bubble[%0d]", k), 32'(o_bubble[k]),  32'(m_bub[k]));
      check($sformatf("busy[%0d]", k),   32'(o_busy[k]),    32'((m_cnt[k] != 0) || m_active[k]));
      check($sformatf("ready[%0d]", k),  32'(o_ready[k]),   32'(m_cnt[k] < DEPTH));
    end
  endtask

  // Called just after a falling edge: apply inputs, advance the model, clock, then compare.
  task automatic step(input logic v, input logic [31:0] w, input logic rst_n);
    in_valid = v;
    in_instr = w;
    RSTn     = rst_n;
    model_step(0);
    model_step(1);
    @(posedge CLK);
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    logic [31:0] w;
    RSTn     = 1'b0;
    in_valid = 1'b0;
    in_instr = 32'h0;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      for (int i = 0; i < DEPTH; i++) m_buf[k][i] = 32'h0;
    end
    @(negedge CLK);

    // Reset, with a push offered during reset that must be dropped.
    step(1'b1, rtype(1, 2, 3), 1'b0);
    step(1'b0, 32'h0, 1'b0);
    idle(2);

    // Dependent pair: one bubble with HAZ_WIN=1, two with HAZ_WIN=2.
    step(1'b1, 32'h01E9A022, 1'b1);
    step(1'b1, 32'h0289A022, 1'b1);
    idle(5);
    check("dep_pair_bubbles_w1", 32'(o_bubble[0]), 32'd1);
    check("dep_pair_bubbles_w2", 32'(o_bubble[1]), 32'd2);

    // Independent pair back-to-back: no bubbles added.
    step(1'b1, 32'h00AF7820, 1'b1);
    step(1'b1, 32'h01294020, 1'b1);
    idle(3);
    check("indep_pair_bubbles_w1", 32'(o_bubble[0]), 32'd1);

    // Hazard chain to fill the buffer; extra pushes at full are dropped.
    for (int i = 0; i < 8; i++) step(1'b1, rtype(8 + i, 0, 9 + i), 1'b1);
    idle(14);

    // Long idle.
    idle(10);
    check("idle_busy", 32'(o_busy[0]), 32'd0);

    // Reset mid-operation with words buffered.
    for (int i = 0; i < 5; i++) step(1'b1, rtype(20 + i, 0, 21 + i), 1'b1);
    step(1'b0, 32'h0, 1'b0);
    check("rst_busy",   32'(o_busy[1]),   32'd0);
    check("rst_ready",  32'(o_ready[1]),  32'd1);
    check("rst_bubble", 32'(o_bubble[1]), 32'd0);
    idle(6);

    // Stream 9 independent words through to exercise pointer wrap.
    for (int i = 0; i < 9; i++) step(1'b1, rtype(1, 2, 8 + i), 1'b1);
    idle(4);

    // Randomized traffic with a small register file to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      w[31:26] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      w[25:21] = 5'($urandom_range(0, 7));
      w[20:16] = 5'($urandom_range(0, 7));
      w[15:11] = 5'($urandom_range(0, 7));
      w[10:0]  = 11'($urandom);
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, w,
           ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1);
    end
    idle(8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
